ram_1r1w_arbiter: RTL and testbench

Sequencer and two-requester arbiter in front of a 1-read/1-write synchronous RAM (`ram_1r1w_sync`-style: registered read, 1-cycle latency). After reset it runs a zero-fill sweep of every entry. It then shares the RAM's write port and read port between two requesters using independent round-robin arbiters. It routes each read response back to its issuer, and forwards same-cycle write data to a colliding read.

---
 rtl/ram_arb_pkg.sv | 13 +
 rtl/rr_arb_2.sv | 41 ++++
 rtl/ram_1r1w_arbiter.sv | 143 ++++++++++++++
 tb/tb_ram_1r1w_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-requester RAM arbiter slice.
package ram_arb_pkg;

    localparam int num_req_lp = 2;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    typedef logic req_idx_t;

endpackage

// File: rtl/rr_arb_2.sv
// Two-way round-robin arbiter: the favoured requester wins when it asks,
// and after any grant the pointer moves to favour the loser.
module rr_arb_2
    import ram_arb_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    req_idx_t ptr_q;
    req_idx_t ptr_d;

    always_comb begin
        grant_o = 2'b00;
        if (req_i[ptr_q]) begin
            grant_o[ptr_q] = 1'b1;
        end else if (req_i[~ptr_q]) begin
            grant_o[~ptr_q] = 1'b1;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_o[0]) begin
            ptr_d = 1'b1;
        end else if (grant_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ram_1r1w_arbiter.sv
// Zero-fill sequencer plus independent read/write round-robin arbitration in
// front of a 1R1W synchronous RAM, with same-cycle write-to-read bypass.
module ram_1r1w_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int width_p = 8,
    parameter  int depth_p = 512,
    localparam int addr_w  = $clog2(depth_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_ni,
    // Handshake: a transfer happens in any cycle where req_valid_i[i] &
    // req_ready_o[i]; the requester keeps valid/we/addr/data stable until then.
    input  logic [num_req_lp-1:0]          req_valid_i,
    output logic [num_req_lp-1:0]          req_ready_o,
    input  logic [num_req_lp-1:0]          req_we_i,
    input  logic [num_req_lp*addr_w-1:0]   req_addr_i,
    input  logic [num_req_lp*width_p-1:0]  req_data_i,
    output logic [num_req_lp-1:0]          rsp_valid_o,
    output logic [width_p-1:0]             rsp_data_o,
    output logic                           init_done_o,
    output logic                           ram_wr_valid_o,
    output logic [addr_w-1:0]              ram_wr_addr_o,
    output logic [width_p-1:0]             ram_wr_data_o,
    output logic                           ram_rd_valid_o,
    output logic [addr_w-1:0]              ram_rd_addr_o,
    input  logic [width_p-1:0]             ram_rd_data_i,
    output state_e                         dbg_state_o
);

    localparam int                depth_i  = depth_p;
    localparam int                last_i   = depth_p - 1;
    localparam logic [addr_w:0]   depth_lp = depth_i[addr_w:0];
    localparam logic [addr_w-1:0] last_lp  = last_i[addr_w-1:0];

    state_e              state_q;
    logic [addr_w-1:0]   clr_addr_q;
    logic                init_done_q;
    logic                run;
    logic [1:0]          wr_req, rd_req, wr_gnt, rd_gnt;
    logic [addr_w-1:0]   wr_addr, rd_addr;
    logic [width_p-1:0]  wr_data;
    logic                wr_in_range, rd_in_range, collide;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic                byp_q, byp_d, oor_q, oor_d;
    logic [width_p-1:0]  byp_data_q, byp_data_d, last_rsp_q, rsp_cur;

    assign run    = (state_q == RUN);
    assign wr_req = run ? (req_valid_i & req_we_i)  : 2'b00;
    assign rd_req = run ? (req_valid_i & ~req_we_i) : 2'b00;

    rr_arb_2 u_wr_arb (.clk_i(clk_i), .reset_ni(reset_ni), .req_i(wr_req), .grant_o(wr_gnt));
    rr_arb_2 u_rd_arb (.clk_i(clk_i), .reset_ni(reset_ni), .req_i(rd_req), .grant_o(rd_gnt));

    assign req_ready_o = wr_gnt | rd_gnt;

    assign wr_addr = wr_gnt[1] ? req_addr_i[2*addr_w-1 -: addr_w] : req_addr_i[addr_w-1:0];
    assign wr_data = wr_gnt[1] ? req_data_i[2*width_p-1 -: width_p] : req_data_i[width_p-1:0];
    assign rd_addr = rd_gnt[1] ? req_addr_i[2*addr_w-1 -: addr_w] : req_addr_i[addr_w-1:0];

    assign wr_in_range = ({1'b0, wr_addr} < depth_lp);
    assign rd_in_range = ({1'b0, rd_addr} < depth_lp);
    assign collide     = (|wr_gnt) && (|rd_gnt) && wr_in_range && rd_in_range
                         && (wr_addr == rd_addr);

    // The sweep write is gated by reset_ni so the RAM sees no write while held in reset.
    always_comb begin
        ram_wr_valid_o = 1'b0;
        ram_wr_addr_o  = '0;
        ram_wr_data_o  = '0;
        ram_rd_valid_o = 1'b0;
        ram_rd_addr_o  = '0;
        if (!run) begin
            ram_wr_valid_o = reset_ni;
            ram_wr_addr_o  = clr_addr_q;
        end else begin
            if (|wr_gnt) begin
                ram_wr_valid_o = wr_in_range;
                ram_wr_addr_o  = wr_addr;
                ram_wr_data_o  = wr_data;
            end
            if (|rd_gnt) begin
                ram_rd_valid_o = rd_in_range;
                ram_rd_addr_o  = rd_addr;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= CLEAR;
            clr_addr_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (clr_addr_q == last_lp) begin
                        state_q     <= RUN;
                        clr_addr_q  <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        clr_addr_q <= clr_addr_q + addr_w'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rsp_valid_d = rd_gnt;
        byp_d       = collide;
        oor_d       = ~rd_in_range;
        byp_data_d  = wr_data;
    end

    // Response source is chosen from flags captured at grant time.
    assign rsp_cur    = byp_q ? byp_data_q : (oor_q ? '0 : ram_rd_data_i);
    assign rsp_data_o = (|rsp_valid_q) ? rsp_cur : last_rsp_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_valid_q <= 2'b00;
            byp_q       <= 1'b0;
            oor_q       <= 1'b0;
            byp_data_q  <= '0;
            last_rsp_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            byp_q       <= byp_d;
            oor_q       <= oor_d;
            byp_data_q  <= byp_data_d;
            if (|rsp_valid_q) begin
                last_rsp_q <= rsp_cur;
            end
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign init_done_o = init_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_1r1w_arbiter.sv
// Bench for ram_1r1w_arbiter: depth 8 and depth 6 instances, each with a RAM
// and a behavioural model checked on every cycle, plus directed literal checks.
module tb_ram_1r1w_arbiter;
    import ram_arb_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;
    localparam int NI = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [1:0]      valid [NI];
    logic [1:0]      we    [NI];
    logic [1:0]      ready [NI];
    logic [1:0]      rsp_v [NI];
    logic [2*AW-1:0] addr  [NI];
    logic [2*W-1:0]  data  [NI];
    logic [W-1:0]    rsp_d [NI];
    logic [W-1:0]    ram_wd [NI];
    logic [W-1:0]    ram_rdata [NI];
    logic            init  [NI];
    logic            ram_wv [NI];
    logic            ram_rv [NI];
    logic [AW-1:0]   ram_wa [NI];
    logic [AW-1:0]   ram_ra [NI];
    state_e          dbg   [NI];
    logic [W-1:0]    ram_mem [NI][8];

    int total = 0;
    int bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs and RAMs ----------------
    ram_1r1w_arbiter #(.width_p(8), .depth_p(8)) u_dut8 (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(valid[0]), .req_ready_o(ready[0]), .req_we_i(we[0]),
        .req_addr_i(addr[0]), .req_data_i(data[0]),
        .rsp_valid_o(rsp_v[0]), .rsp_data_o(rsp_d[0]), .init_done_o(init[0]),
        .ram_wr_valid_o(ram_wv[0]), .ram_wr_addr_o(ram_wa[0]), .ram_wr_data_o(ram_wd[0]),
        .ram_rd_valid_o(ram_rv[0]), .ram_rd_addr_o(ram_ra[0]), .ram_rd_data_i(ram_rdata[0]),
        .dbg_state_o(dbg[0])
    );

    ram_1r1w_arbiter #(.width_p(8), .depth_p(6)) u_dut6 (
        .clk_i(clk), .reset_ni(rst_n),
        .req_valid_i(valid[1]), .req_ready_o(ready[1]), .req_we_i(we[1]),
        .req_addr_i(addr[1]), .req_data_i(data[1]),
        .rsp_valid_o(rsp_v[1]), .rsp_data_o(rsp_d[1]), .init_done_o(init[1]),
        .ram_wr_valid_o(ram_wv[1]), .ram_wr_addr_o(ram_wa[1]), .ram_wr_data_o(ram_wd[1]),
        .ram_rd_valid_o(ram_rv[1]), .ram_rd_addr_o(ram_ra[1]), .ram_rd_data_i(ram_rdata[1]),
        .dbg_state_o(dbg[1])
    );

    for (genvar g = 0; g < NI; g++) begin : g_ram
        always @(posedge clk) begin
            if (ram_wv[g]) ram_mem[g][ram_wa[g]] <= ram_wd[g];
            if (ram_rv[g]) ram_rdata[g] <= ram_mem[g][ram_ra[g]];
        end
    end

    // ---------------- scoreboard / model ----------------
    int          m_cyc   [NI];
    bit          m_fav_w [NI];
    bit          m_fav_r [NI];
    logic [1:0]  m_rv    [NI];
    logic [W-1:0] m_rd   [NI];
    logic [W-1:0] m_mem  [NI][8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [1:0] c, input bit fav);
        if (c[fav]) return int'(fav);
        if (c[!fav]) return int'(!fav);
        return -1;
    endfunction

    task automatic model_step(input int d);
        int dep, gw, gr, wa, ra;
        logic [1:0] er;
        logic [W-1:0] wd;
        string p;
        dep = (d == 0) ? 8 : 6;
        p = $sformatf("d%0d", dep);
        wa = 0; ra = 0; wd = '0; er = 2'b00;
        if (!rst_n) begin
            check({p, " rst ready"}, ready[d], 0);
            check({p, " rst rsp_valid"}, rsp_v[d], 0);
            check({p, " rst rsp_data"}, rsp_d[d], 0);
            check({p, " rst init_done"}, init[d], 0);
            check({p, " rst wr_valid"}, ram_wv[d], 0);
            check({p, " rst rd_valid"}, ram_rv[d], 0);
            check({p, " rst state"}, dbg[d], CLEAR);
            m_cyc[d] = 0; m_fav_w[d] = 0; m_fav_r[d] = 0; m_rv[d] = 2'b00; m_rd[d] = '0;
        end else begin
            check({p, " init_done"}, init[d], (m_cyc[d] >= dep) ? 1 : 0);
            check({p, " state"}, dbg[d], (m_cyc[d] >= dep) ? RUN : CLEAR);
            check({p, " rsp_valid"}, rsp_v[d], m_rv[d]);
            check({p, " rsp_data"}, rsp_d[d], m_rd[d]);
            if (m_cyc[d] < dep) begin
                check({p, " sweep ready"}, ready[d], 0);
                check({p, " sweep rd_valid"}, ram_rv[d], 0);
                check({p, " sweep wr_valid"}, ram_wv[d], 1);
                check({p, " sweep wr_addr"}, ram_wa[d], m_cyc[d]);
                check({p, " sweep wr_data"}, ram_wd[d], 0);
                m_mem[d][m_cyc[d]] = '0;
                m_cyc[d]++;
                m_rv[d] = 2'b00;
            end else begin
                gw = pick(valid[d] & we[d], m_fav_w[d]);
                gr = pick(valid[d] & ~we[d], m_fav_r[d]);
                if (gw >= 0) begin
                    er[gw] = 1'b1;
                    wa = int'(addr[d][gw*AW +: AW]);
                    wd = data[d][gw*W +: W];
                end
                if (gr >= 0) begin
                    er[gr] = 1'b1;
                    ra = int'(addr[d][gr*AW +: AW]);
                end
                check({p, " ready"}, ready[d], er);
                if (gw < 0) begin
                    check({p, " idle wr_valid"}, ram_wv[d], 0);
                    check({p, " idle wr_addr"}, ram_wa[d], 0);
                    check({p, " idle wr_data"}, ram_wd[d], 0);
                end else if (wa < dep) begin
                    check({p, " wr_valid"}, ram_wv[d], 1);
                    check({p, " wr_addr"}, ram_wa[d], wa);
                    check({p, " wr_data"}, ram_wd[d], wd);
                end else begin
                    check({p, " oor wr_valid"}, ram_wv[d], 0);
                end
                if (gr < 0) begin
                    check({p, " idle rd_valid"}, ram_rv[d], 0);
                    check({p, " idle rd_addr"}, ram_ra[d], 0);
                end else if (ra < dep) begin
                    check({p, " rd_valid"}, ram_rv[d], 1);
                    check({p, " rd_addr"}, ram_ra[d], ra);
                end
                if (gr >= 0) begin
                    m_rv[d] = 2'b01 << gr;
                    if (ra >= dep) m_rd[d] = '0;
                    else if (gw >= 0 && wa == ra) m_rd[d] = wd;
                    else m_rd[d] = m_mem[d][ra];
                end else begin
                    m_rv[d] = 2'b00;
                end
                if (gw >= 0 && wa < dep) m_mem[d][wa] = wd;
                if (gw >= 0) m_fav_w[d] = (gw == 0);
                if (gr >= 0) m_fav_r[d] = (gr == 0);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < NI; d++) model_step(d);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int d, input int r, input bit v, input bit w,
                         input int a, input int dat);
        valid[d][r] = v;
        we[d][r] = w;
        addr[d][r*AW +: AW] = a[AW-1:0];
        data[d][r*W +: W] = dat[W-1:0];
    endtask

    task automatic idle_all();
        for (int d = 0; d < NI; d++) begin
            drive(d, 0, 0, 0, 0, 0);
            drive(d, 1, 0, 0, 0, 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n0, n1;
        int ea [4];
        bit acc [NI][2];
        ea = '{0, 1, 2, 7};
        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset init_done", init[0], 0);
        check("reset wr_valid", ram_wv[0], 0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("sweep step addr", ram_wa[0], k);
            check("sweep step ready", ready[0], 0);
        end
        @(negedge clk);
        check("init_done after 8 cycles", init[0], 1);

        // Both requesters write; grant order must be 0,1,0,1.
        n0 = 0; n1 = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(0, 0, n0 < 2, 1, (n0 == 0) ? 0 : 2, 8'h40 + ((n0 == 0) ? 0 : 2));
            drive(0, 1, n1 < 2, 1, (n1 == 0) ? 1 : 7, 8'h40 + ((n1 == 0) ? 1 : 7));
            @(negedge clk);
            check("alternate grant", ready[0], (k % 2 == 0) ? 2'b01 : 2'b10);
            check("alternate wr_addr", ram_wa[0], ea[k]);
            if (ready[0][0]) n0++;
            if (ready[0][1]) n1++;
        end
        tick();
        idle_all();

        // Write then read from the other requester.
        drive(0, 0, 1, 1, 3, 8'hA5);
        @(negedge clk);
        check("wr3 ready", ready[0], 2'b01);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 1, 1, 0, 3, 0);
        @(negedge clk);
        check("rd3 ready", ready[0], 2'b10);
        tick();
        idle_all();
        @(negedge clk);
        check("rd3 rsp_valid", rsp_v[0], 2'b10);
        check("rd3 rsp_data", rsp_d[0], 8'hA5);

        // Same-cycle collision must return the new write data.
        tick();
        drive(0, 0, 1, 1, 5, 8'h3C);
        drive(0, 1, 1, 0, 5, 0);
        @(negedge clk);
        check("collide ready", ready[0], 2'b11);
        tick();
        idle_all();
        @(negedge clk);
        check("collide rsp_valid", rsp_v[0], 2'b10);
        check("collide rsp_data", rsp_d[0], 8'h3C);

        // Concurrent read and write to different addresses.
        tick();
        drive(0, 0, 1, 0, 2, 0);
        drive(0, 1, 1, 1, 6, 8'h11);
        @(negedge clk);
        check("concurrent ready", ready[0], 2'b11);
        check("concurrent rd_valid", ram_rv[0], 1);
        check("concurrent wr_valid", ram_wv[0], 1);
        tick();
        idle_all();
        @(negedge clk);
        check("concurrent rsp_valid", rsp_v[0], 2'b01);
        check("concurrent rsp_data", rsp_d[0], 8'h42);

        // Reset right after a read accept drops the response and re-sweeps.
        tick();
        drive(0, 0, 1, 0, 3, 0);
        @(negedge clk);
        check("pre-reset rd ready", ready[0], 2'b01);
        tick();
        idle_all();
        check("pre-reset rsp_valid", rsp_v[0], 2'b01);
        check("pre-reset rsp_data", rsp_d[0], 8'hA5);
        rst_n = 1'b0;
        #1;
        check("mid-reset rsp_valid", rsp_v[0], 0);
        check("mid-reset init_done", init[0], 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        @(negedge clk);
        check("re-sweep init_done", init[0], 1);
        tick();
        drive(0, 0, 1, 0, 3, 0);
        @(negedge clk);
        check("post-reset rd ready", ready[0], 2'b01);
        tick();
        idle_all();
        @(negedge clk);
        check("post-reset rsp_valid", rsp_v[0], 2'b01);
        check("post-reset rsp_data", rsp_d[0], 8'h00);

        // Random traffic on both instances, including out-of-range addresses
        // on the depth-6 instance and one reset pulse.
        for (int d = 0; d < NI; d++) begin
            acc[d][0] = 1'b0;
            acc[d][1] = 1'b0;
        end
        for (int c = 0; c < 800; c++) begin
            tick();
            if (c == 400) rst_n = 1'b0;
            if (c == 402) rst_n = 1'b1;
            for (int d = 0; d < NI; d++) begin
                for (int r = 0; r < 2; r++) begin
                    if (!valid[d][r] || acc[d][r]) begin
                        if ($urandom_range(0, 3) != 0)
                            drive(d, r, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                                  int'($urandom_range(0, 255)));
                        else
                            drive(d, r, 0, 0, 0, 0);
                    end
                end
            end
            @(negedge clk);
            for (int d = 0; d < NI; d++) begin
                for (int r = 0; r < 2; r++) acc[d][r] = valid[d][r] & ready[d][r];
            end
        end
        tick();
        idle_all();
        repeat (3) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
